// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared cache/memory-path types and widths
package rv32i_types;

    localparam int LINE_WIDTH = 256;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_GRANT = 2'd1,
        D_GRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - icache/dcache miss-path arbiter onto one memory line port
// Optional round-robin tie-break when CACHE_ARBITER_RR_EN is defined.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = rv32i_types::LINE_WIDTH,
    parameter int ADDR_WIDTH = rv32i_types::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state;
    arb_state_t state_next;
    logic       d_req;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
    // 0: icache was granted last, 1: dcache was granted last
    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                last_grant <= (state_next == D_GRANT);
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
`ifdef CACHE_ARBITER_RR_EN
                if (d_req && i_read) begin
                    state_next = last_grant ? I_GRANT : D_GRANT;
                end else if (d_req) begin
                    state_next = D_GRANT;
                end else if (i_read) begin
                    state_next = I_GRANT;
                end
`else
                if (d_req) begin
                    state_next = D_GRANT;
                end else if (i_read) begin
                    state_next = I_GRANT;
                end
`endif
            end
            // The grant is held until memory completes, regardless of request bits.
            I_GRANT, D_GRANT: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (rst) begin
            i_rdata = '0;
            d_rdata = '0;
        end else begin
            unique case (state)
                I_GRANT: begin
                    pmem_read    = 1'b1;
                    pmem_address = i_address;
                    i_resp       = pmem_resp;
                end
                // A simultaneous read+write from the dcache is resolved as a write.
                D_GRANT: begin
                    pmem_write   = d_write;
                    pmem_read    = d_read & ~d_write;
                    pmem_address = d_address;
                    pmem_wdata   = d_wdata;
                    d_resp       = pmem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed table-driven bench for cache_arbiter
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;

    int total = 0;
    int bad   = 0;

    localparam logic [AW-1:0] IADDR = 32'h0000_0100;
    localparam logic [AW-1:0] DADDR = 32'h0000_2000;
    logic [LW-1:0] data_aa;
    logic [LW-1:0] data_55;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ir, dr, dw, pr;
        logic [1:0] epr;
        logic       epw, eir, edr;
        logic [1:0] esel;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // epr==2 leaves pmem_read unchecked; esel: 0 none, 1 icache, 2 dcache
    task automatic step(input logic ir, dr, dw, pr, input logic [1:0] epr,
                        input logic epw, eir, edr, input logic [1:0] esel, input string nm);
        logic [AW-1:0] ea;
        i_read = ir; d_read = dr; d_write = dw; pmem_resp = pr;
        ea = (esel == 2'd1) ? IADDR : (esel == 2'd2) ? DADDR : '0;
        @(negedge clk);
        if (epr != 2'd2) chk({nm, ".pmem_read"}, LW'(pmem_read), LW'(epr[0]));
        chk({nm, ".pmem_write"}, LW'(pmem_write), LW'(epw));
        chk({nm, ".i_resp"}, LW'(i_resp), LW'(eir));
        chk({nm, ".d_resp"}, LW'(d_resp), LW'(edr));
        chk({nm, ".pmem_address"}, LW'(pmem_address), LW'(ea));
        if (esel != 2'd1) chk({nm, ".pmem_wdata"}, pmem_wdata, (esel == 2'd2) ? data_55 : '0);
        if (eir) chk({nm, ".i_rdata"}, i_rdata, data_aa);
        if (edr) chk({nm, ".d_rdata"}, d_rdata, data_aa);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b1; d_read = 1'b0; d_write = 1'b1; pmem_resp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.pmem_read", LW'(pmem_read), '0);
        chk("reset.pmem_write", LW'(pmem_write), '0);
        chk("reset.resp", LW'({i_resp, d_resp}), '0);
        chk("reset.pmem_address", LW'(pmem_address), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    endtask

    initial begin
        data_aa = {(LW/8){8'hAA}};
        data_55 = {(LW/8){8'h55}};
        i_address = IADDR; d_address = DADDR; d_wdata = data_55; pmem_rdata = data_aa;
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; rst = 1;

        tbl[0]  = '{1,0,0,0, 0,0,0,0,0};
        tbl[1]  = '{1,0,0,0, 1,0,0,0,1};
        tbl[2]  = '{1,0,0,0, 1,0,0,0,1};
        tbl[3]  = '{1,0,0,1, 1,0,1,0,1};
        tbl[4]  = '{0,0,0,0, 0,0,0,0,0};
        tbl[5]  = '{0,0,1,0, 0,0,0,0,0};
        tbl[6]  = '{0,0,1,0, 0,1,0,0,2};
        tbl[7]  = '{0,0,1,1, 0,1,0,1,2};
        tbl[8]  = '{0,0,0,0, 0,0,0,0,0};
        tbl[9]  = '{0,1,1,0, 0,0,0,0,0};
        tbl[10] = '{0,1,1,0, 0,1,0,0,2};
        tbl[11] = '{0,1,1,1, 0,1,0,1,2};
        tbl[12] = '{0,0,0,0, 0,0,0,0,0};

        @(posedge clk);
        #1;
        do_reset();

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].pr, tbl[k].epr,
                 tbl[k].epw, tbl[k].eir, tbl[k].edr, tbl[k].esel, $sformatf("vec%0d", k));
        end

        // collisions from a fresh reset (last grant = icache)
        do_reset();
        step(1,1,0,0, 0,0,0,0,0, "col1.idle");
        step(1,1,0,1, 1,0,0,1,2, "col1.dgrant");
        step(0,0,0,0, 0,0,0,0,0, "col1.gap");
        step(1,1,0,0, 0,0,0,0,0, "col2.idle");
`ifdef CACHE_ARBITER_RR_EN
        step(1,1,0,1, 1,0,1,0,1, "col2.first_i");
        step(0,1,0,0, 0,0,0,0,0, "col2.gap");
        step(0,1,0,1, 1,0,0,1,2, "col2.then_d");
`else
        step(1,1,0,1, 1,0,0,1,2, "col2.first_d");
        step(1,0,0,0, 0,0,0,0,0, "col2.gap");
        step(1,0,0,1, 1,0,1,0,1, "col2.then_i");
`endif
        step(0,0,0,0, 0,0,0,0,0, "col2.done");

        // icache request dropped one cycle after grant
        step(1,0,0,0, 0,0,0,0,0, "drop.idle");
        step(1,0,0,0, 1,0,0,0,1, "drop.grant");
        step(0,0,0,0, 2,0,0,0,1, "drop.held");
        step(0,0,0,1, 2,0,1,0,1, "drop.resp");
        step(0,0,0,0, 0,0,0,0,0, "drop.idle2");

        // reset pulse in the second cycle of a dcache write-back
        step(0,0,1,0, 0,0,0,0,0, "rstmid.idle");
        step(0,0,1,0, 0,1,0,0,2, "rstmid.c1");
        rst = 1'b1; pmem_resp = 1'b1;
        #1;
        chk("rstmid.pmem_write", LW'(pmem_write), '0);
        chk("rstmid.d_resp", LW'(d_resp), '0);
        @(negedge clk);
        #1;
        rst = 1'b0; pmem_resp = 1'b0;
        @(posedge clk);
        #1;
        step(0,0,1,0, 0,1,0,0,2, "rstmid.regrant");
        step(0,0,1,1, 0,1,0,1,2, "rstmid.resp");
        step(0,0,0,0, 0,0,0,0,0, "rstmid.done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
